wb_commit: RTL and testbench
============================

# wb_commit

Writeback/commit stage on the consumer side of the MEM/WB pipeline register. It takes the registered MEM/WB payload, drives the architectural register-file write port, and keeps a 64-bit retired-instruction counter. It also pushes one commit record per retired instruction into a small FIFO, which a trace/difftest sink drains through a valid/ready handshake. When the FIFO cannot accept a record, the block raises a stall back to the pipeline.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: commit-record FIFO depth; power of two, ≥ 2.
- `DATA_WIDTH`, default taken from `pipeline_pkg` (64): register and data width.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `data_i`  in  `MEMWB_Pipe_Out_t`  MEM/WB payload. Fields used: `PC`, `PC_Next`, `RD_Addr`, `Reg_WEn`, `WB_Data`, `Mem_REn`, `enable`.
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  `DATA_WIDTH`  register-file write data.
- `stall_o`  out  1  commit blocked; upstream must hold MEM/WB contents.
- `trace_valid_o`  out  1  FIFO head record is valid.
- `trace_ready_i`  in  1  sink accepts the head record.
- `trace_o`  out  `Commit_Rec_t`  FIFO head record.
- `minstret_o`  out  64  count of retired instructions.

## Operation
- `pop = trace_valid_o && trace_ready_i`.
- `full` = FIFO holds `FIFO_DEPTH` entries.
- `stall_o = rst_ni && full && !pop`. This path is combinational from `trace_ready_i`.
- `commit = rst_ni && data_i.enable && !stall_o`.
- Register-file write:
  - `rf_we_o = commit && data_i.Reg_WEn && (data_i.RD_Addr != 0)`.
  - `rf_waddr_o = data_i.RD_Addr`; `rf_wdata_o = data_i.WB_Data`. Both are combinational.
  - Writes to x0 are always suppressed.
- On `commit`, push a `Commit_Rec_t` with these fields:
  - `pc = data_i.PC`, `pc_next = data_i.PC_Next`, `rd = data_i.RD_Addr`.
  - `we = data_i.Reg_WEn && rd != 0`, `data = data_i.WB_Data`, `is_load = data_i.Mem_REn`.
  - `seq = minstret_o`, i.e. the counter value before increment.
- `minstret_o` increments by 1 on each `commit`. It wraps modulo 2^64.
- Bubble (`enable = 0`): no write, no record, no count, `stall_o` unaffected.
- Push and pop in the same cycle are legal in every occupancy state:
  - When full with a pop, the push is accepted and occupancy is unchanged.
  - When empty, a push and a pop cannot coincide, because the record only appears the following cycle.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally. The extra MSB distinguishes full from empty.
- FIFO head is first-word-fall-through from registered storage. `trace_o` is stable while `trace_valid_o && !trace_ready_i`.

## Timing
- Register-file write takes effect at the same edge that `commit` is evaluated, so latency is 0 cycles from `data_i`.
- The trace record becomes visible, with `trace_valid_o = 1`, in the cycle after the commit edge.
- `minstret_o` shows the new value in the cycle after the commit edge.
- Reset, with `rst_ni` low sampled at an edge:
  - FIFO emptied, pointers cleared.
  - `minstret_o = 0`, `trace_valid_o = 0`.
  - `rf_we_o = 0` and `stall_o = 0` for the whole reset cycle, combinationally gated.
- Reset mid-operation discards all queued records. No partial record is ever output.
- When `stall_o` is high, the upstream stage re-presents the same `data_i`. The record is committed once, in the first cycle it is not stalled.

## Structure
- Add `Commit_Rec_t` (packed: `pc`, `pc_next`, `rd`, `we`, `data`, `is_load`, `seq[63:0]`) to `pipeline_pkg`.
- Reuse the existing `MEMWB_Pipe_Out_t` and `DATA_WIDTH` from the package.
- Sub-module `commit_fifo`: parameterised synchronous FIFO.
  - Ports: `push`, `din`, `pop`, `dout`, `full`, `empty`; active-low synchronous reset.
  - Instantiated once.
  - Counter and stall/commit logic stay in `wb_commit`.

## Test plan
- **Reset:** hold `rst_ni = 0` for 2 cycles with `data_i.enable = 1`, `Reg_WEn = 1`, `RD_Addr = 3` → `rf_we_o = 0`, `stall_o = 0`, `trace_valid_o = 0`, `minstret_o = 0`.
- **Single commit:** `PC = 0x8000_0000`, `PC_Next = 0x8000_0004`, `RD_Addr = 5`, `WB_Data = 0x1234`, `Reg_WEn = 1`, `trace_ready_i = 1` → same cycle `rf_we_o = 1`, `rf_waddr_o = 5`. Next cycle `trace_valid_o = 1`, `trace_o.seq = 0`, `trace_o.pc = 0x8000_0000`, `minstret_o = 1`.
- **x0 write:** `RD_Addr = 0`, `Reg_WEn = 1`, `Mem_REn = 1` → `rf_we_o = 0`; record has `we = 0`, `is_load = 1`; `minstret_o` increments.
- **Backpressure with `FIFO_DEPTH = 4`:** `trace_ready_i = 0`, 5 back-to-back commits →
  - After 4 commits, `stall_o = 1`; the 5th is not committed (`rf_we_o = 0`, `minstret_o = 4`).
  - Raise `trace_ready_i` → `stall_o = 0` in the same cycle and the 5th commits.
  - Drained records come out in order with `seq` 0..4.
- **Bubbles interleaved:** sequence enable 1,0,1 → 2 records with `seq` 0,1; no `rf_we_o` during the bubble.
- **Reset mid-operation:** 3 queued records, `trace_ready_i = 0`, then assert `rst_ni = 0` for one edge → `trace_valid_o = 0`, `minstret_o = 0`. The next commit yields `seq = 0`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: MEM/WB payload and the per-instruction commit record
// consumed by the trace/difftest sink.
package pipeline_pkg;

   localparam int DATA_WIDTH = 64;

   typedef struct packed {
      logic [63:0]           PC;
      logic [63:0]           PC_Next;
      logic [4:0]            RD_Addr;
      logic                  Reg_WEn;
      logic [DATA_WIDTH-1:0] WB_Data;
      logic                  Mem_REn;
      logic                  enable;
   } MEMWB_Pipe_Out_t;

   typedef struct packed {
      logic [63:0]           pc;
      logic [63:0]           pc_next;
      logic [4:0]            rd;
      logic                  we;
      logic [DATA_WIDTH-1:0] data;
      logic                  is_load;
      logic [63:0]           seq;
   } Commit_Rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO with first-word-fall-through head from registered storage.
// Pointers carry one extra MSB so full and empty are distinguishable.
module commit_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is only taken when the head leaves this cycle.
   assign w_push = push && (!full || pop);
   assign w_pop  = pop && !empty;

   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign dout  = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: register-file write port, retired-instruction counter,
// and a commit-record FIFO whose backpressure stalls the pipeline.
module wb_commit
   import pipeline_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  MEMWB_Pipe_Out_t       data_i,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  stall_o,
   output logic                  trace_valid_o,
   input  logic                  trace_ready_i,
   output Commit_Rec_t           trace_o,
   output logic [63:0]           minstret_o
);

   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_commit;
   logic        w_rd_nz;
   Commit_Rec_t w_rec;
   logic [63:0] r_minstret;

   assign trace_valid_o = !w_empty;
   assign w_pop         = trace_valid_o && trace_ready_i;
   // A pop frees the slot this cycle, so a full FIFO need not stall.
   assign stall_o       = rst_ni && w_full && !w_pop;
   assign w_commit      = rst_ni && data_i.enable && !stall_o;
   assign w_rd_nz       = (data_i.RD_Addr != 5'd0);

   assign rf_we_o    = w_commit && data_i.Reg_WEn && w_rd_nz;
   assign rf_waddr_o = data_i.RD_Addr;
   assign rf_wdata_o = data_i.WB_Data;

   always_comb begin
      w_rec         = '0;
      w_rec.pc      = data_i.PC;
      w_rec.pc_next = data_i.PC_Next;
      w_rec.rd      = data_i.RD_Addr;
      w_rec.we      = data_i.Reg_WEn && w_rd_nz;
      w_rec.data    = data_i.WB_Data;
      w_rec.is_load = data_i.Mem_REn;
      w_rec.seq     = r_minstret;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)       r_minstret <= '0;
      else if (w_commit) r_minstret <= r_minstret + 64'd1;
   end

   assign minstret_o = r_minstret;

   commit_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(Commit_Rec_t))
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (w_commit),
      .din    (w_rec),
      .pop    (w_pop),
      .dout   (trace_o),
      .full   (w_full),
      .empty  (w_empty)
   );

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed scenarios plus randomized traffic against a
// queue-based model of the commit record stream and retired count.
module tb_wb_commit;
   import pipeline_pkg::*;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   MEMWB_Pipe_Out_t data_i = '0;
   logic            trace_ready_i = 1'b0;
   logic            rf_we_o;
   logic [4:0]      rf_waddr_o;
   logic [63:0]     rf_wdata_o;
   logic            stall_o;
   logic            trace_valid_o;
   Commit_Rec_t     trace_o;
   logic [63:0]     minstret_o;

   int n_tests = 0;
   int n_fail  = 0;

   Commit_Rec_t     q[$];
   logic [63:0]     cnt = '0;
   logic [63:0]     obs_seq[$];
   logic            last_commit;

   always #5 clk = ~clk;

   wb_commit #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .data_i        (data_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .stall_o       (stall_o),
      .trace_valid_o (trace_valid_o),
      .trace_ready_i (trace_ready_i),
      .trace_o       (trace_o),
      .minstret_o    (minstret_o)
   );

   // One clock cycle: drive inputs, check outputs against the model before
   // the edge, then advance the model by what the edge must do.
   task automatic step(input logic rst, input logic en, input logic [63:0] pc,
                       input logic [63:0] pcn, input logic [4:0] rd, input logic we,
                       input logic [63:0] d, input logic ld, input logic rdy);
      logic        e_pop, e_stall, e_commit, e_we;
      Commit_Rec_t rec;
      @(negedge clk);
      rst_ni = rst;
      data_i.enable = en;  data_i.PC = pc;  data_i.PC_Next = pcn;
      data_i.RD_Addr = rd; data_i.Reg_WEn = we; data_i.WB_Data = d;
      data_i.Mem_REn = ld; trace_ready_i = rdy;
      #1;
      e_pop    = (q.size() != 0) && rdy;
      e_stall  = rst && (q.size() == DEPTH) && !e_pop;
      e_commit = rst && en && !e_stall;
      e_we     = e_commit && we && (rd != 5'd0);
      n_tests++;
      if (rf_we_o !== e_we) begin
         n_fail++; $display("FAIL rf_we: got %b exp %b", rf_we_o, e_we);
      end
      n_tests++;
      if (stall_o !== e_stall) begin
         n_fail++; $display("FAIL stall: got %b exp %b", stall_o, e_stall);
      end
      if (e_we) begin
         n_tests++;
         if (rf_waddr_o !== rd || rf_wdata_o !== d) begin
            n_fail++; $display("FAIL rf_port: got %0d/%h exp %0d/%h", rf_waddr_o, rf_wdata_o, rd, d);
         end
      end
      if (rst) begin
         n_tests++;
         if (trace_valid_o !== (q.size() != 0)) begin
            n_fail++; $display("FAIL trace_valid: got %b exp %b", trace_valid_o, q.size() != 0);
         end
         n_tests++;
         if (minstret_o !== cnt) begin
            n_fail++; $display("FAIL minstret: got %0d exp %0d", minstret_o, cnt);
         end
         if (q.size() != 0) begin
            n_tests++;
            if (trace_o !== q[0]) begin
               n_fail++; $display("FAIL trace_rec: got %h exp %h", trace_o, q[0]);
            end
         end
         if (trace_valid_o === 1'b1 && rdy) obs_seq.push_back(trace_o.seq);
      end
      if (!rst) begin
         q.delete();
         cnt = '0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_commit) begin
            rec.pc = pc; rec.pc_next = pcn; rec.rd = rd; rec.we = we && (rd != 5'd0);
            rec.data = d; rec.is_load = ld; rec.seq = cnt;
            q.push_back(rec);
            cnt = cnt + 64'd1;
         end
      end
      last_commit = e_commit;
   endtask

   task automatic idle(input logic rdy);
      step(1'b1, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) step(1'b0, 1'b1, 64'h100, 64'h104, 5'd3, 1'b1, 64'hAA, 1'b0, 1'b1);
      idle(1'b0);
      n_tests++;
      if (trace_valid_o !== 1'b0 || minstret_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_state: got v=%b cnt=%0d exp v=0 cnt=0", trace_valid_o, minstret_o);
      end
   endtask

   task automatic test_single();
      do_reset();
      step(1'b1, 1'b1, 64'h8000_0000, 64'h8000_0004, 5'd5, 1'b1, 64'h1234, 1'b0, 1'b1);
      n_tests++;
      if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5) begin
         n_fail++; $display("FAIL single_we: got %b/%0d exp 1/5", rf_we_o, rf_waddr_o);
      end
      idle(1'b1);
      n_tests++;
      if (trace_valid_o !== 1'b1 || trace_o.seq !== 64'd0 || trace_o.pc !== 64'h8000_0000 || minstret_o !== 64'd1) begin
         n_fail++; $display("FAIL single_rec: got v=%b seq=%0d pc=%h cnt=%0d exp 1/0/80000000/1",
                            trace_valid_o, trace_o.seq, trace_o.pc, minstret_o);
      end
   endtask

   task automatic test_x0();
      logic [63:0] c0;
      idle(1'b1);
      c0 = minstret_o;
      step(1'b1, 1'b1, 64'h200, 64'h204, 5'd0, 1'b1, 64'hDEAD, 1'b1, 1'b0);
      n_tests++;
      if (rf_we_o !== 1'b0) begin
         n_fail++; $display("FAIL x0_we: got %b exp 0", rf_we_o);
      end
      idle(1'b0);
      n_tests++;
      if (trace_o.we !== 1'b0 || trace_o.is_load !== 1'b1 || minstret_o !== c0 + 64'd1) begin
         n_fail++; $display("FAIL x0_rec: got we=%b ld=%b cnt=%0d exp 0/1/%0d",
                            trace_o.we, trace_o.is_load, minstret_o, c0 + 64'd1);
      end
      repeat (2) idle(1'b1);
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 64'h1000 + 64'(i*4), 64'h1004 + 64'(i*4), 5'(i+1), 1'b1, 64'(i), 1'b0, 1'b0);
      step(1'b1, 1'b1, 64'h1010, 64'h1014, 5'd9, 1'b1, 64'h55, 1'b0, 1'b0);
      n_tests++;
      if (stall_o !== 1'b1 || rf_we_o !== 1'b0 || minstret_o !== 64'd4) begin
         n_fail++; $display("FAIL bp_full: got stall=%b we=%b cnt=%0d exp 1/0/4", stall_o, rf_we_o, minstret_o);
      end
      obs_seq.delete();
      step(1'b1, 1'b1, 64'h1010, 64'h1014, 5'd9, 1'b1, 64'h55, 1'b0, 1'b1);
      n_tests++;
      if (stall_o !== 1'b0 || rf_we_o !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got stall=%b we=%b exp 0/1", stall_o, rf_we_o);
      end
      repeat (6) idle(1'b1);
      n_tests++;
      if (obs_seq.size() != 5) begin
         n_fail++; $display("FAIL bp_drain_cnt: got %0d exp 5", obs_seq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (obs_seq[i] !== 64'(i)) begin
               n_fail++; $display("FAIL bp_order: got %0d exp %0d", obs_seq[i], i);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      do_reset();
      obs_seq.delete();
      step(1'b1, 1'b1, 64'h300, 64'h304, 5'd7, 1'b1, 64'h1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 64'h304, 64'h308, 5'd8, 1'b1, 64'h2, 1'b0, 1'b1);
      n_tests++;
      if (rf_we_o !== 1'b0) begin
         n_fail++; $display("FAIL bubble_we: got %b exp 0", rf_we_o);
      end
      step(1'b1, 1'b1, 64'h308, 64'h30C, 5'd9, 1'b1, 64'h3, 1'b0, 1'b1);
      repeat (3) idle(1'b1);
      n_tests++;
      if (obs_seq.size() != 2 || obs_seq[0] !== 64'd0 || obs_seq[1] !== 64'd1) begin
         n_fail++; $display("FAIL bubble_seq: got n=%0d exp 2 records seq 0,1", obs_seq.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 64'h400 + 64'(i*4), 64'h404 + 64'(i*4), 5'd4, 1'b1, 64'(i), 1'b0, 1'b0);
      do_reset();
      idle(1'b0);
      n_tests++;
      if (trace_valid_o !== 1'b0 || minstret_o !== 64'd0) begin
         n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d exp 0/0", trace_valid_o, minstret_o);
      end
      step(1'b1, 1'b1, 64'h500, 64'h504, 5'd6, 1'b1, 64'h77, 1'b0, 1'b0);
      idle(1'b0);
      n_tests++;
      if (trace_valid_o !== 1'b1 || trace_o.seq !== 64'd0) begin
         n_fail++; $display("FAIL mid_reset_seq: got v=%b seq=%0d exp 1/0", trace_valid_o, trace_o.seq);
      end
   endtask

   task automatic test_random();
      logic [63:0] pc, d;
      logic [4:0]  rd;
      logic        en, we, ld;
      do_reset();
      last_commit = 1'b1;
      en = 1'b0; pc = 64'h8000_0000; d = '0; rd = '0; we = 1'b0; ld = 1'b0;
      for (int i = 0; i < 400; i++) begin
         // Stalled payloads are re-presented unchanged, as upstream would.
         if (last_commit || !en) begin
            en = ($urandom % 4) != 0;
            pc = pc + 64'd4;
            rd = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
            we = $urandom % 2;
            ld = $urandom % 2;
            d  = {$urandom, $urandom};
         end
         if (($urandom % 97) == 0) do_reset();
         else step(1'b1, en, pc, pc + 64'd4, rd, we, d, ld, ($urandom % 3) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_x0();
      test_backpressure();
      test_bubbles();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
